mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and drives the data-memory request/acknowledge handshake.
- Resolves the branch decision (pc_src) and produces the MEM/WB pipeline register for writeback.
- Stalls the upstream pipeline while a memory access is outstanding; aborts the access on timeout or misalignment.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/mem_stage_if.sv | 25 ++
 rtl/ex_mem_reg.sv | 24 ++
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS MEM stage: FSM states and the EX/MEM and MEM/WB pipeline records.
package mips_pkg;

    localparam int DEF_ADDR_W = 16;

    typedef enum logic {
        RUN    = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  write_register;
        logic [31:0] branch_target;
        logic        zero;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_register;
    } mem_wb_t;

    function automatic logic is_mem_op(ex_mem_t e);
        return e.valid & (e.mem_read | e.mem_write);
    endfunction

    // Word accesses only: any nonzero low address bit makes the access illegal.
    function automatic logic is_aligned_mem_op(ex_mem_t e);
        return is_mem_op(e) & (e.alu_result[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: async active-low reset, loads only when enabled (held during stalls).
module ex_mem_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    i_en,
    input  ex_mem_t i_d,
    output ex_mem_t o_q
);

    ex_mem_t r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, data-memory handshake FSM with
// timeout/misalignment abort, branch resolution and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_write_register,
    input  logic [31:0] ex_branch_target,
    input  logic        ex_zero,
    input  logic        ex_ctrl_branch,
    input  logic        ex_ctrl_mem_read,
    input  logic        ex_ctrl_mem_write,
    input  logic        ex_ctrl_reg_write,
    input  logic        ex_ctrl_mem_to_reg,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_register,
    output logic        bus_error,
    output logic        misaligned
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_state_t r_state, w_nextState;
    logic [7:0] r_waitCnt, w_nextWaitCnt;
    mem_wb_t    r_memWb, w_nextMemWb;
    logic       r_busError, r_misaligned;
    ex_mem_t    w_exIn, w_exMem;
    logic       w_stall, w_timeout, w_inMisaligned;

    assign w_exIn = '{valid: ex_valid, alu_result: ex_alu_result, store_data: ex_store_data,
                      write_register: ex_write_register, branch_target: ex_branch_target,
                      zero: ex_zero, branch: ex_ctrl_branch, mem_read: ex_ctrl_mem_read,
                      mem_write: ex_ctrl_mem_write, reg_write: ex_ctrl_reg_write,
                      mem_to_reg: ex_ctrl_mem_to_reg};

    ex_mem_reg u_exMemReg (
        .clk   (clk),
        .reset (reset),
        .i_en  (~w_stall),
        .i_d   (w_exIn),
        .o_q   (w_exMem)
    );

    assign w_inMisaligned = is_mem_op(w_exIn) & (w_exIn.alu_result[1:0] != 2'b00);

    // Non-ack ACCESS cycles and misaligned/aborted ops in RUN all write a bubble into MEM/WB.
    always_comb begin
        w_stall       = (r_state == ACCESS) & ~dmem.dmem_ack;
        w_timeout     = w_stall & (r_waitCnt == TO_LAST);
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_nextMemWb   = '0;
        case (r_state)
            RUN: begin
                if (!is_mem_op(w_exMem)) begin
                    w_nextMemWb = '{valid: w_exMem.valid, reg_write: w_exMem.reg_write,
                                    mem_to_reg: w_exMem.mem_to_reg, read_data: 32'd0,
                                    alu_result: w_exMem.alu_result,
                                    write_register: w_exMem.write_register};
                end
                if (is_aligned_mem_op(w_exIn)) begin
                    w_nextState   = ACCESS;
                    w_nextWaitCnt = 8'd0;
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack) begin
                    w_nextMemWb = '{valid: 1'b1, reg_write: w_exMem.reg_write,
                                    mem_to_reg: w_exMem.mem_to_reg,
                                    read_data: w_exMem.mem_read ? dmem.dmem_rdata : 32'd0,
                                    alu_result: w_exMem.alu_result,
                                    write_register: w_exMem.write_register};
                    w_nextWaitCnt = 8'd0;
                    if (!is_aligned_mem_op(w_exIn)) begin
                        w_nextState = RUN;
                    end
                end else if (w_timeout) begin
                    w_nextState = RUN;
                end else begin
                    w_nextWaitCnt = r_waitCnt + 8'd1;
                end
            end
            default: w_nextState = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RUN;
            r_waitCnt    <= 8'd0;
            r_memWb      <= '0;
            r_busError   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_waitCnt    <= w_nextWaitCnt;
            r_memWb      <= w_nextMemWb;
            r_busError   <= w_timeout;
            r_misaligned <= ~w_stall & w_inMisaligned;
        end
    end

    assign stall             = w_stall;
    assign pc_src            = w_exMem.valid & w_exMem.branch & w_exMem.zero;
    assign branch_target     = w_exMem.branch_target;
    assign dmem.dmem_req     = (r_state == ACCESS);
    assign dmem.dmem_we      = (r_state == ACCESS) & w_exMem.mem_write;
    assign dmem.dmem_addr    = (r_state == ACCESS) ? w_exMem.alu_result[ADDR_W-1:0] : '0;
    assign dmem.dmem_wdata   = (r_state == ACCESS) ? w_exMem.store_data : 32'd0;
    assign wb_valid          = r_memWb.valid;
    assign wb_reg_write      = r_memWb.reg_write;
    assign wb_mem_to_reg     = r_memWb.mem_to_reg;
    assign wb_read_data      = r_memWb.read_data;
    assign wb_alu_result     = r_memWb.alu_result;
    assign wb_write_register = r_memWb.write_register;
    assign bus_error         = r_busError;
    assign misaligned        = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ALU/branch vectors plus hand-written
// load/store, back-to-back, misalignment, timeout and reset-mid-access sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exValid;
    logic [31:0] exAluResult, exStoreData, exBranchTarget;
    logic [4:0]  exWriteRegister;
    logic        exZero, exBranch, exMemRead, exMemWrite, exRegWrite, exMemToReg;
    logic        stall, pcSrc;
    logic [31:0] branchTarget;
    logic        wbValid, wbRegWrite, wbMemToReg;
    logic [31:0] wbReadData, wbAluResult;
    logic [4:0]  wbWriteRegister;
    logic        busError, misaligned;

    int checks = 0;
    int errors = 0;

    mem_stage_if #(.ADDR_W(16)) dmemIf ();

    mem_stage #(.ADDR_W(16), .TIMEOUT(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .ex_valid           (exValid),
        .ex_alu_result      (exAluResult),
        .ex_store_data      (exStoreData),
        .ex_write_register  (exWriteRegister),
        .ex_branch_target   (exBranchTarget),
        .ex_zero            (exZero),
        .ex_ctrl_branch     (exBranch),
        .ex_ctrl_mem_read   (exMemRead),
        .ex_ctrl_mem_write  (exMemWrite),
        .ex_ctrl_reg_write  (exRegWrite),
        .ex_ctrl_mem_to_reg (exMemToReg),
        .stall              (stall),
        .pc_src             (pcSrc),
        .branch_target      (branchTarget),
        .dmem               (dmemIf),
        .wb_valid           (wbValid),
        .wb_reg_write       (wbRegWrite),
        .wb_mem_to_reg      (wbMemToReg),
        .wb_read_data       (wbReadData),
        .wb_alu_result      (wbAluResult),
        .wb_write_register  (wbWriteRegister),
        .bus_error          (busError),
        .misaligned         (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        regWrite;
        logic        branch;
        logic        zero;
        logic [31:0] target;
        logic        expPcSrc;
        logic [31:0] expTarget;
        logic        expWbValid;
        logic [31:0] expWbAlu;
        logic [4:0]  expWbWreg;
        logic        expWbRegWrite;
    } vector_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] alu, input logic [31:0] storeData,
                                 input logic [4:0] wreg, input logic [31:0] target, input logic zero,
                                 input logic branch, input logic memRead, input logic memWrite,
                                 input logic regWrite, input logic memToReg);
        exValid         = valid;
        exAluResult     = alu;
        exStoreData     = storeData;
        exWriteRegister = wreg;
        exBranchTarget  = target;
        exZero          = zero;
        exBranch        = branch;
        exMemRead       = memRead;
        exMemWrite      = memWrite;
        exRegWrite      = regWrite;
        exMemToReg      = memToReg;
    endtask

    task automatic applyBubble();
        applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t vectors[5];
        int stallCycles;
        int busErrorPulses;
        int wbValidSeen;

        vectors[0] = '{1'b1, 32'h0000_0010, 5'd5,  1'b1, 1'b0, 1'b0, 32'h0,
                       1'b0, 32'h0,         1'b1, 32'h0000_0010, 5'd5,  1'b1};
        vectors[1] = '{1'b1, 32'h0000_0000, 5'd0,  1'b0, 1'b1, 1'b1, 32'h0000_0100,
                       1'b1, 32'h0000_0100, 1'b1, 32'h0000_0000, 5'd0,  1'b0};
        vectors[2] = '{1'b1, 32'h0000_0004, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0000_0200,
                       1'b0, 32'h0000_0200, 1'b1, 32'h0000_0004, 5'd0,  1'b0};
        vectors[3] = '{1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b1, 1'b1, 32'h0000_0300,
                       1'b0, 32'h0000_0300, 1'b0, 32'h0000_0000, 5'd0,  1'b0};
        vectors[4] = '{1'b1, 32'hFFFF_FFFC, 5'd31, 1'b1, 1'b0, 1'b0, 32'h0,
                       1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 5'd31, 1'b1};

        reset = 1'b0;
        applyBubble();
        dmemIf.dmem_ack   = 1'b0;
        dmemIf.dmem_rdata = 32'd0;
        #12;
        checkOutput("resetStall", 32'(stall), 32'd0);
        checkOutput("resetReq", 32'(dmemIf.dmem_req), 32'd0);
        checkOutput("resetWbValid", 32'(wbValid), 32'd0);
        checkOutput("resetPcSrc", 32'(pcSrc), 32'd0);
        checkOutput("resetBusError", 32'(busError), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single-cycle instructions: branch outputs one cycle after apply, writeback one after that.
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(vectors[i].valid, vectors[i].alu, 32'd0, vectors[i].wreg, vectors[i].target,
                          vectors[i].zero, vectors[i].branch, 1'b0, 1'b0, vectors[i].regWrite, 1'b0);
            nextCycle();
            checkOutput($sformatf("vec%0d_pcSrc", i), 32'(pcSrc), 32'(vectors[i].expPcSrc));
            checkOutput($sformatf("vec%0d_target", i), branchTarget, vectors[i].expTarget);
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            checkOutput($sformatf("vec%0d_req", i), 32'(dmemIf.dmem_req), 32'd0);
            applyBubble();
            nextCycle();
            checkOutput($sformatf("vec%0d_wbValid", i), 32'(wbValid), 32'(vectors[i].expWbValid));
            checkOutput($sformatf("vec%0d_wbAlu", i), wbAluResult, vectors[i].expWbAlu);
            checkOutput($sformatf("vec%0d_wbWreg", i), 32'(wbWriteRegister), 32'(vectors[i].expWbWreg));
            checkOutput($sformatf("vec%0d_wbRegWrite", i), 32'(wbRegWrite), 32'(vectors[i].expWbRegWrite));
        end

        // Load at 0x40 acknowledged in the fourth ACCESS cycle.
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0040, 32'd0, 5'd8, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            checkOutput($sformatf("loadStall%0d", c), 32'(stall), 32'd1);
            checkOutput($sformatf("loadReq%0d", c), 32'(dmemIf.dmem_req), 32'd1);
            if (c == 0) begin
                checkOutput("loadAddr", 32'(dmemIf.dmem_addr), 32'h0000_0040);
                checkOutput("loadWe", 32'(dmemIf.dmem_we), 32'd0);
            end
            applyBubble();
        end
        nextCycle();
        dmemIf.dmem_ack   = 1'b1;
        dmemIf.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("loadAckStall", 32'(stall), 32'd0);
        checkOutput("loadAckReq", 32'(dmemIf.dmem_req), 32'd1);
        nextCycle();
        dmemIf.dmem_ack   = 1'b0;
        dmemIf.dmem_rdata = 32'd0;
        checkOutput("loadWbValid", 32'(wbValid), 32'd1);
        checkOutput("loadWbData", wbReadData, 32'hDEAD_BEEF);
        checkOutput("loadWbMemToReg", 32'(wbMemToReg), 32'd1);
        checkOutput("loadWbWreg", 32'(wbWriteRegister), 32'd8);
        checkOutput("loadDoneReq", 32'(dmemIf.dmem_req), 32'd0);

        // Zero-wait store immediately followed by a load: request never drops between them.
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0044, 32'h1234_5678, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        dmemIf.dmem_ack   = 1'b1;
        dmemIf.dmem_rdata = 32'hAAAA_5555;
        applyStimulus(1'b1, 32'h0000_0048, 32'd0, 5'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("storeReq", 32'(dmemIf.dmem_req), 32'd1);
        checkOutput("storeWe", 32'(dmemIf.dmem_we), 32'd1);
        checkOutput("storeWdata", dmemIf.dmem_wdata, 32'h1234_5678);
        checkOutput("storeAddr", 32'(dmemIf.dmem_addr), 32'h0000_0044);
        checkOutput("storeStall", 32'(stall), 32'd0);
        nextCycle();
        applyBubble();
        dmemIf.dmem_rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("b2bReq", 32'(dmemIf.dmem_req), 32'd1);
        checkOutput("b2bAddr", 32'(dmemIf.dmem_addr), 32'h0000_0048);
        checkOutput("b2bWe", 32'(dmemIf.dmem_we), 32'd0);
        checkOutput("b2bStall", 32'(stall), 32'd0);
        checkOutput("storeWbValid", 32'(wbValid), 32'd1);
        checkOutput("storeWbData", wbReadData, 32'd0);
        checkOutput("storeWbAlu", wbAluResult, 32'h0000_0044);
        nextCycle();
        dmemIf.dmem_ack   = 1'b0;
        dmemIf.dmem_rdata = 32'd0;
        checkOutput("b2bWbData", wbReadData, 32'hCAFE_F00D);
        checkOutput("b2bWbWreg", 32'(wbWriteRegister), 32'd9);
        checkOutput("b2bDoneReq", 32'(dmemIf.dmem_req), 32'd0);

        // ALU op then misaligned load at 0x42: the load becomes a bubble with a misaligned pulse.
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0033, 32'd0, 5'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0042, 32'd0, 5'd6, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        nextCycle();
        checkOutput("misalignedPulse", 32'(misaligned), 32'd1);
        checkOutput("misalignedReq", 32'(dmemIf.dmem_req), 32'd0);
        checkOutput("misalignedStall", 32'(stall), 32'd0);
        checkOutput("misalignedPrevWb", 32'(wbValid), 32'd1);
        applyBubble();
        nextCycle();
        checkOutput("misalignedPulseEnd", 32'(misaligned), 32'd0);
        checkOutput("misalignedWbValid", 32'(wbValid), 32'd0);
        checkOutput("misalignedReqAfter", 32'(dmemIf.dmem_req), 32'd0);

        // Load that is never acknowledged: TIMEOUT stall cycles, then one bus_error pulse.
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0050, 32'd0, 5'd7, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        stallCycles    = 0;
        busErrorPulses = 0;
        wbValidSeen    = 0;
        for (int c = 0; c < 12; c++) begin
            nextCycle();
            if (c == 0) applyBubble();
            if (stall) stallCycles++;
            if (busError) busErrorPulses++;
            if (wbValid) wbValidSeen++;
        end
        checkOutput("timeoutStallCycles", 32'(stallCycles), 32'd8);
        checkOutput("timeoutBusErrors", 32'(busErrorPulses), 32'd1);
        checkOutput("timeoutWbValid", 32'(wbValidSeen), 32'd0);
        checkOutput("timeoutReqAfter", 32'(dmemIf.dmem_req), 32'd0);
        applyStimulus(1'b1, 32'h0000_0021, 32'd0, 5'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyBubble();
        nextCycle();
        checkOutput("afterTimeoutWbValid", 32'(wbValid), 32'd1);
        checkOutput("afterTimeoutWbAlu", wbAluResult, 32'h0000_0021);

        // Reset asserted while a load waits for its ack.
        applyStimulus(1'b1, 32'h0000_0077, 32'd0, 5'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0060, 32'd0, 5'd10, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        nextCycle();
        checkOutput("preResetReq", 32'(dmemIf.dmem_req), 32'd1);
        checkOutput("preResetStall", 32'(stall), 32'd1);
        checkOutput("preResetWbValid", 32'(wbValid), 32'd1);
        checkOutput("preResetWbAlu", wbAluResult, 32'h0000_0077);
        applyBubble();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midResetReq", 32'(dmemIf.dmem_req), 32'd0);
        checkOutput("midResetStall", 32'(stall), 32'd0);
        checkOutput("midResetWbValid", 32'(wbValid), 32'd0);
        checkOutput("midResetWbAlu", wbAluResult, 32'd0);
        checkOutput("midResetWbWreg", 32'(wbWriteRegister), 32'd0);
        checkOutput("midResetWbRegWrite", 32'(wbRegWrite), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        nextCycle();
        checkOutput("postResetReq", 32'(dmemIf.dmem_req), 32'd0);
        checkOutput("postResetWbValid", 32'(wbValid), 32'd0);
        checkOutput("postResetStall", 32'(stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
